// File: rtl/flash_sample_streamer.sv
// Streams packed PCM words from the flash Avalon port into the codec write handshake,
// one attenuated mono sample at a time, with normal/fast/slow/pause rates and loop or one-shot playback.
module flash_sample_streamer #(
   parameter int unsigned ADDR_W           = 23,
   parameter int unsigned WORD_W           = 32,
   parameter int unsigned SAMPLE_W         = 16,
   parameter int unsigned SAMPLES_PER_WORD = 2,
   parameter int unsigned START_ADDR       = 0,
   parameter int unsigned END_ADDR         = 1048575,
   parameter int unsigned SHIFT            = 6,
   parameter int unsigned SLOW_REPEAT      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [1:0]          mode,
   input  logic                loop,
   output logic                flash_mem_read,
   output logic [ADDR_W-1:0]   flash_mem_address,
   input  logic                flash_mem_waitrequest,
   input  logic [WORD_W-1:0]   flash_mem_readdata,
   input  logic                flash_mem_readdatavalid,
   input  logic                write_ready,
   output logic                write_s,
   output logic [SAMPLE_W-1:0] writedata_left,
   output logic [SAMPLE_W-1:0] writedata_right,
   output logic                done
);

   localparam int unsigned IDX_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;
   localparam int unsigned CNT_W = $clog2(SLOW_REPEAT) + 1;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_FAST   = 2'b01;
   localparam logic [1:0] MODE_SLOW   = 2'b10;
   localparam logic [1:0] MODE_PAUSE  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      WAIT_READY,
      SEND,
      WAIT_ACCEPT,
      NEXT,
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                haveWord_q, haveWord_d;
   logic                needNext_q, needNext_d;

   logic [IDX_W:0]      idxInc;
   logic [CNT_W-1:0]    cntInc;
   logic                lastSample;
   logic [IDX_W-1:0]    stepIdx;
   logic [CNT_W-1:0]    stepCnt;
   logic                stepWord;
   logic                stopReq;

   logic signed [SAMPLE_W-1:0] slice;
   logic signed [SAMPLE_W:0]   biased;
   logic [SAMPLE_W-1:0]        scaled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= ADDR_W'(START_ADDR);
         word_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         haveWord_q <= 1'b0;
         needNext_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         haveWord_q <= haveWord_d;
         needNext_q <= needNext_d;
      end
   end

   // Position after the current sample completes; pause advances like normal so a resume continues forward.
   always_comb begin
      idxInc     = {1'b0, idx_q} + (IDX_W+1)'(1);
      cntInc     = cnt_q + CNT_W'(1);
      lastSample = (idxInc == (IDX_W+1)'(SAMPLES_PER_WORD));
      stepIdx    = idx_q;
      stepCnt    = cnt_q;
      stepWord   = 1'b0;
      if (mode == MODE_FAST) begin
         stepIdx  = '0;
         stepCnt  = '0;
         stepWord = 1'b1;
      end else if ((mode == MODE_SLOW) && (cntInc < CNT_W'(SLOW_REPEAT))) begin
         stepCnt = cntInc;
      end else begin
         stepCnt = '0;
         if (lastSample) begin
            stepIdx  = '0;
            stepWord = 1'b1;
         end else begin
            stepIdx = idxInc[IDX_W-1:0];
         end
      end
      stopReq = !enable || (mode == MODE_PAUSE);
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      haveWord_d = haveWord_q;
      needNext_d = needNext_q;
      case (state_q)
         IDLE: begin
            if (enable && (mode != MODE_PAUSE)) begin
               if (needNext_q) begin
                  needNext_d = 1'b0;
                  state_d    = NEXT;
               end else if (haveWord_q) begin
                  state_d = WAIT_READY;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (!flash_mem_waitrequest) begin
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (flash_mem_readdatavalid) begin
               word_d     = flash_mem_readdata;
               idx_d      = '0;
               cnt_d      = '0;
               haveWord_d = 1'b1;
               state_d    = WAIT_READY;
            end
         end
         WAIT_READY: begin
            if (write_ready) begin
               state_d = SEND;
            end
         end
         SEND: begin
            state_d = WAIT_ACCEPT;
         end
         WAIT_ACCEPT: begin
            if (!write_ready) begin
               idx_d = stepIdx;
               cnt_d = stepCnt;
               if (stepWord) begin
                  haveWord_d = 1'b0;
               end
               if (stopReq) begin
                  needNext_d = stepWord;
                  state_d    = IDLE;
               end else if (stepWord) begin
                  state_d = NEXT;
               end else begin
                  state_d = WAIT_READY;
               end
            end
         end
         NEXT: begin
            haveWord_d = 1'b0;
            if (addr_q == ADDR_W'(END_ADDR)) begin
               if (loop) begin
                  addr_d  = ADDR_W'(START_ADDR);
                  state_d = REQ;
               end else begin
                  state_d = DONE;
               end
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = REQ;
            end
         end
         DONE: begin
            if (!enable) begin
               addr_d  = ADDR_W'(START_ADDR);
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Signed divide by 2**SHIFT rounding toward zero: bias negatives before the arithmetic shift.
   always_comb begin
      slice = '0;
      for (int i = 0; i < int'(SAMPLES_PER_WORD); i++) begin
         if (idx_q == IDX_W'(i)) begin
            slice = word_q[i*SAMPLE_W +: SAMPLE_W];
         end
      end
      biased = {slice[SAMPLE_W-1], slice}
             + (slice[SAMPLE_W-1] ? (SAMPLE_W+1)'((1 << SHIFT) - 1) : (SAMPLE_W+1)'(0));
      scaled = SAMPLE_W'(biased >>> SHIFT);
   end

   always_comb begin
      flash_mem_read  = 1'b0;
      write_s         = 1'b0;
      writedata_left  = '0;
      writedata_right = '0;
      done            = 1'b0;
      case (state_q)
         REQ: begin
            flash_mem_read = 1'b1;
         end
         WAIT_READY: begin
            writedata_left  = scaled;
            writedata_right = scaled;
         end
         SEND, WAIT_ACCEPT: begin
            write_s         = 1'b1;
            writedata_left  = scaled;
            writedata_right = scaled;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign flash_mem_address = addr_q;

endmodule
